// File: rtl/cpu_pkg.sv
// Shared constants and types for the register-file writeback path.
//   XLEN     - writeback data width
//   NREG     - number of architectural registers
//   AW       - register index width
//   wb_req_t - one writeback request {rd, data}
//   REG_ZERO - index of the hard-wired zero register
package cpu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_slot.sv
// One-entry writeback holding slot with a valid/ready handshake.
//   clock, reset - rising-edge clock, asynchronous active-high reset
//   flush        - empties the slot at the next edge and drops any transfer there
//   in_valid     - producer offers a request
//   in_req       - offered {rd, data}
//   in_ready     - slot accepts this cycle (empty, or being drained now)
//   grant        - scheduler drains the slot this cycle
//   slot_valid   - slot holds a request
//   slot_req     - held {rd, data}
//   loaded       - slot captures a new request at the coming edge
module wb_slot
  import cpu_pkg::*;
(
  input  logic    clock,
  input  logic    reset,
  input  logic    flush,
  input  logic    in_valid,
  input  wb_req_t in_req,
  output logic    in_ready,
  input  logic    grant,
  output logic    slot_valid,
  output wb_req_t slot_req,
  output logic    loaded
);

  logic    valid_q, valid_d;
  wb_req_t req_q, req_d;

  // Ready is forced low while reset is held so no producer hands off into a dead slot.
  assign in_ready = !reset && (!valid_q || grant);

  // Writes to x0 complete the handshake but are never stored.
  assign loaded = in_valid && in_ready && (in_req.rd != REG_ZERO) && !flush;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (loaded) begin
      valid_d = 1'b1;
      req_d   = in_req;
    end else if (grant) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      req_q   <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
    end
  end

  assign slot_valid = valid_q;
  assign slot_req   = req_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Schedules the single register-file write port between the ALU and the memory unit.
// Each source has a one-entry slot; full slots drain one per cycle, oldest first.
//   clock, reset           - rising-edge clock, asynchronous active-high reset
//   flush                  - empties both slots at the next edge
//   alu_valid/ready/rd/data - ALU writeback handshake
//   mem_valid/ready/rd/data - memory/load writeback handshake
//   rf_we/rf_waddr/rf_wdata - register-file write port (zeroed when idle)
//   pending_mask           - bit r set while a queued write to xr is outstanding
module regfile_wb_scheduler
  import cpu_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic [NREG-1:0] pending_mask
);

  wb_req_t alu_in, mem_in;
  wb_req_t alu_slot, mem_slot;
  logic    alu_v, mem_v;
  logic    alu_grant, mem_grant;
  logic    alu_load, mem_load;
  logic    mem_older_q, mem_older_d;

  assign alu_in = '{rd: alu_rd, data: alu_data};
  assign mem_in = '{rd: mem_rd, data: mem_data};

  wb_slot u_alu_slot (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (alu_valid),
    .in_req     (alu_in),
    .in_ready   (alu_ready),
    .grant      (alu_grant),
    .slot_valid (alu_v),
    .slot_req   (alu_slot),
    .loaded     (alu_load)
  );

  wb_slot u_mem_slot (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (mem_valid),
    .in_req     (mem_in),
    .in_ready   (mem_ready),
    .grant      (mem_grant),
    .slot_valid (mem_v),
    .slot_req   (mem_slot),
    .loaded     (mem_load)
  );

  // Grant depends only on registered slot state, so ready never depends on valid.
  assign mem_grant = mem_v && (!alu_v || mem_older_q);
  assign alu_grant = alu_v && (!mem_v || !mem_older_q);

  // The slot loaded alone is the younger one; a simultaneous load makes MEM older
  // because the load was issued earlier in program order. When only one slot ends
  // up full the bit is don't-care, so holding it is harmless.
  always_comb begin
    mem_older_d = mem_older_q;
    if (mem_load && alu_load) begin
      mem_older_d = 1'b1;
    end else if (mem_load) begin
      mem_older_d = 1'b0;
    end else if (alu_load) begin
      mem_older_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_older_q <= 1'b0;
    end else begin
      mem_older_q <= mem_older_d;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (mem_grant) begin
      rf_we    = 1'b1;
      rf_waddr = mem_slot.rd;
      rf_wdata = mem_slot.data;
    end else if (alu_grant) begin
      rf_we    = 1'b1;
      rf_waddr = alu_slot.rd;
      rf_wdata = alu_slot.data;
    end
  end

  always_comb begin
    pending_mask = '0;
    if (alu_v) pending_mask[alu_slot.rd] = 1'b1;
    if (mem_v) pending_mask[mem_slot.rd] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;
  import cpu_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid, mem_ready;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] pending_mask;

  int vectors    = 0;
  int miscompares = 0;
  int write_idx  = 0;
  wb_req_t exp_q[$];

  always #5 clock = ~clock;

  regfile_wb_scheduler dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_mask (pending_mask)
  );

  // Scoreboard monitor: every register-file write is popped and compared in order.
  always @(negedge clock) begin
    if (rf_we) begin
      wb_req_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_%0d: got x%0d=%h, expected no write", write_idx, rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        if (rf_waddr !== e.rd || rf_wdata !== e.data) begin
          miscompares++;
          $display("FAIL write_%0d: got x%0d=%h, expected x%0d=%h",
                   write_idx, rf_waddr, rf_wdata, e.rd, e.data);
        end
      end
      write_idx++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_write(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    flush     = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #2;
    check("reset_alu_ready", 64'(alu_ready), 64'd0);
    check("reset_mem_ready", 64'(mem_ready), 64'd0);
    check("reset_rf_we", 64'(rf_we), 64'd0);
    check("reset_pending", 64'(pending_mask), 64'd0);
    step();
    step();
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_alu_ready", 64'(alu_ready), 64'd1);
    check("post_reset_mem_ready", 64'(mem_ready), 64'd1);
    check("idle_waddr", 64'(rf_waddr), 64'd0);
    check("idle_wdata", rf_wdata, 64'd0);

    // Single ALU write to x5.
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'hDEAD;
    expect_write(5'd5, 64'hDEAD);
    #1 check("t1_alu_ready", 64'(alu_ready), 64'd1);
    step();
    idle_inputs();
    @(negedge clock);
    check("t1_pending_set", 64'(pending_mask), 64'h20);
    step();
    @(negedge clock);
    check("t1_pending_clr", 64'(pending_mask), 64'd0);

    // Simultaneous load: MEM is older and drains first.
    step();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'h22;
    expect_write(5'd7, 64'h22);
    expect_write(5'd3, 64'h11);
    step();
    idle_inputs();
    @(negedge clock);
    check("t2_alu_ready_stall", 64'(alu_ready), 64'd0);
    check("t2_mem_ready", 64'(mem_ready), 64'd1);
    check("t2_pending_both", 64'(pending_mask), 64'h88);
    step();
    @(negedge clock);
    check("t2_pending_alu", 64'(pending_mask), 64'h08);
    step();
    @(negedge clock);
    check("t2_pending_clr", 64'(pending_mask), 64'd0);

    // Same-rd ordering with age updates while the other slot stays full.
    step();
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'hC1;
    mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 64'hD1;
    expect_write(5'd13, 64'hD1);
    expect_write(5'd12, 64'hC1);
    expect_write(5'd9, 64'hA);
    expect_write(5'd9, 64'hB);
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 64'hA;
    @(negedge clock);
    check("t3_mem_ready_refill", 64'(mem_ready), 64'd1);
    check("t3_alu_ready_hold", 64'(alu_ready), 64'd0);
    step();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'hB;
    @(negedge clock);
    check("t3_alu_ready_refill", 64'(alu_ready), 64'd1);
    check("t3_mem_ready_hold", 64'(mem_ready), 64'd0);
    step();
    idle_inputs();
    @(negedge clock);
    check("t3_pending_x9", 64'(pending_mask), 64'h200);
    step();
    step();
    @(negedge clock);
    check("t3_pending_clr", 64'(pending_mask), 64'd0);

    // x0 write: handshake completes, nothing stored.
    step();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFFFF;
    #1 check("t4_alu_ready", 64'(alu_ready), 64'd1);
    step();
    idle_inputs();
    @(negedge clock);
    check("t4_rf_we", 64'(rf_we), 64'd0);
    check("t4_pending", 64'(pending_mask), 64'd0);

    // Flush with both slots full: only the current grant writes.
    step();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 64'h66;
    expect_write(5'd6, 64'h66);
    step();
    alu_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 64'hAA;  // dropped by flush
    flush = 1'b1;
    @(negedge clock);
    check("t5_flush_mem_ready", 64'(mem_ready), 64'd1);
    step();
    idle_inputs();
    @(negedge clock);
    check("t5_rf_we_after", 64'(rf_we), 64'd0);
    check("t5_pending_after", 64'(pending_mask), 64'd0);
    step();
    @(negedge clock);
    check("t5_rf_we_later", 64'(rf_we), 64'd0);

    // Asynchronous reset between edges with both slots full.
    step();
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 64'hE;
    mem_valid = 1'b1; mem_rd = 5'd15; mem_data = 64'hF;
    step();
    idle_inputs();
    check("t6_pending_full", 64'(pending_mask), 64'hC000);
    reset = 1'b1;
    #1;
    check("t6_rst_rf_we", 64'(rf_we), 64'd0);
    check("t6_rst_pending", 64'(pending_mask), 64'd0);
    check("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
    check("t6_rst_mem_ready", 64'(mem_ready), 64'd0);
    step();
    reset = 1'b0;
    @(negedge clock);
    check("t6_alu_ready_back", 64'(alu_ready), 64'd1);
    check("t6_mem_ready_back", 64'(mem_ready), 64'd1);
    check("t6_rf_we_back", 64'(rf_we), 64'd0);

    step();
    step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
